// File: rtl/arm_lsu.sv
// Load/store unit: turns one byte/half/word request into word-wide accesses on the
// arm_memory data port, with big-endian lanes, read-modify-write sub-word stores and faults.
module arm_lsu #(
  parameter bit          ALIGN_CHECK  = 1'b1,
  parameter bit          TEXT_PROTECT = 1'b1,
  parameter logic [31:0] TEXT_TOP     = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_fault,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_in,
  output logic        mem_we,
  input  logic        mem_excpt,
  input  logic [31:0] mem_data_out
);

  typedef enum logic [1:0] {StIdle, StAccess, StWrite, StResp} state_e;

  localparam logic [1:0] FaultOk        = 2'b00;
  localparam logic [1:0] FaultMisalign  = 2'b01;
  localparam logic [1:0] FaultUnmapped  = 2'b10;
  localparam logic [1:0] FaultProtected = 2'b11;

  state_e      state_q, state_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] merged_q, merged_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  fault_q, fault_d;
  logic        misaligned;

  // Big-endian lane extraction; byte k lives in bits [31-8k -: 8].
  function automatic logic [31:0] load_lane(input logic [31:0] word, input logic [1:0] size,
                                            input logic sgn, input logic [1:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    unique case (a)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    h = a[1] ? word[15:0] : word[31:16];
    unique case (size)
      2'b00:   load_lane = {{24{sgn & b[7]}}, b};
      2'b01:   load_lane = {{16{sgn & h[15]}}, h};
      default: load_lane = word;
    endcase
  endfunction

  function automatic logic [31:0] merge_lane(input logic [31:0] word, input logic [31:0] wd,
                                             input logic [1:0] size, input logic [1:0] a);
    merge_lane = word;
    unique case (size)
      2'b00: begin
        unique case (a)
          2'd0:    merge_lane[31:24] = wd[7:0];
          2'd1:    merge_lane[23:16] = wd[7:0];
          2'd2:    merge_lane[15:8]  = wd[7:0];
          default: merge_lane[7:0]   = wd[7:0];
        endcase
      end
      2'b01: begin
        if (a[1]) merge_lane[15:0] = wd[15:0];
        else      merge_lane[31:16] = wd[15:0];
      end
      default: merge_lane = wd;
    endcase
  endfunction

  assign misaligned = ALIGN_CHECK &&
                      (((req_size == 2'b01) && req_addr[0]) ||
                       (req_size[1] && (req_addr[1:0] != 2'b00)));

  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    size_d   = size_q;
    signed_d = signed_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    merged_d = merged_q;
    rdata_d  = rdata_q;
    fault_d  = fault_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          write_d  = req_write;
          size_d   = req_size;
          signed_d = req_signed;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          if (misaligned) begin
            fault_d = FaultMisalign;
            if (!req_write) rdata_d = '0;
            state_d = StResp;
          end else if (TEXT_PROTECT && req_write && (req_addr < TEXT_TOP)) begin
            fault_d = FaultProtected;
            state_d = StResp;
          end else begin
            state_d = StAccess;
          end
        end
      end
      StAccess: begin
        if (mem_excpt) begin
          fault_d = FaultUnmapped;
          if (!write_q) rdata_d = '0;
          state_d = StResp;
        end else if (!write_q) begin
          fault_d = FaultOk;
          rdata_d = load_lane(mem_data_out, size_q, signed_q, addr_q[1:0]);
          state_d = StResp;
        end else begin
          merged_d = merge_lane(mem_data_out, wdata_q, size_q, addr_q[1:0]);
          state_d  = StWrite;
        end
      end
      StWrite: begin
        fault_d = FaultOk;
        state_d = StResp;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      write_q  <= 1'b0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      merged_q <= '0;
      rdata_q  <= '0;
      fault_q  <= FaultOk;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      merged_q <= merged_d;
      rdata_q  <= rdata_d;
      fault_q  <= fault_d;
    end
  end

  // mem_we is a pure state decode, so a write already in flight commits even under reset.
  always_comb begin
    req_ready   = (state_q == StIdle) && !reset;
    resp_valid  = (state_q == StResp);
    resp_rdata  = rdata_q;
    resp_fault  = fault_q;
    mem_we      = (state_q == StWrite);
    mem_addr    = ((state_q == StAccess) || (state_q == StWrite)) ?
                  {addr_q[31:2], 2'b00} : 32'h0;
    mem_data_in = mem_we ? merged_q : 32'h0;
  end

endmodule

// File: tb/tb_arm_lsu.sv
// Bench for arm_lsu: two instances (default and relaxed parameters) share one
// word memory model; directed vector table plus hand-written reset sequences.
module tb_arm_lsu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;

  logic        rdy_a, rdy_b, rv_a, rv_b, we_a, we_b;
  logic [31:0] rd_a, rd_b, ma_a, ma_b, md_a, md_b;
  logic [1:0]  ft_a, ft_b;

  logic        m_we, m_excpt, m_rv;
  logic [31:0] m_addr, m_wdata, m_rdata, m_rd;
  logic [1:0]  m_ft;

  logic [31:0] text_mem [64];
  logic [31:0] data_mem [64];

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  int resp_cnt = 0;
  int touch_cnt = 0;
  logic [31:0] watch_addr = 32'hFFFF_FFFF;

  always #5 clk = ~clk;

  arm_lsu u_dut_a (
    .clk(clk), .reset(reset), .req_valid(req_valid && !sel), .req_ready(rdy_a),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv_a), .resp_rdata(rd_a),
    .resp_fault(ft_a), .mem_addr(ma_a), .mem_data_in(md_a), .mem_we(we_a),
    .mem_excpt(m_excpt), .mem_data_out(m_rdata)
  );

  arm_lsu #(.ALIGN_CHECK(1'b0), .TEXT_PROTECT(1'b0)) u_dut_b (
    .clk(clk), .reset(reset), .req_valid(req_valid && sel), .req_ready(rdy_b),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv_b), .resp_rdata(rd_b),
    .resp_fault(ft_b), .mem_addr(ma_b), .mem_data_in(md_b), .mem_we(we_b),
    .mem_excpt(m_excpt), .mem_data_out(m_rdata)
  );

  assign m_addr  = sel ? ma_b : ma_a;
  assign m_wdata = sel ? md_b : md_a;
  assign m_we    = sel ? we_b : we_a;
  assign m_rv    = sel ? rv_b : rv_a;
  assign m_rd    = sel ? rd_b : rd_a;
  assign m_ft    = sel ? ft_b : ft_a;

  // Text at 0x0000_0000..0xFF, data at 0x1000_0000..0xFF, everything else unmapped.
  always_comb begin
    m_excpt = 1'b1;
    m_rdata = 32'h0;
    if (m_addr[31:8] == 24'h0) begin
      m_excpt = 1'b0;
      m_rdata = text_mem[m_addr[7:2]];
    end else if (m_addr[31:8] == 24'h10_0000) begin
      m_excpt = 1'b0;
      m_rdata = data_mem[m_addr[7:2]];
    end
  end

  always @(posedge clk) begin
    if (m_we && !m_excpt) begin
      if (m_addr[31:8] == 24'h0) text_mem[m_addr[7:2]] <= m_wdata;
      else                       data_mem[m_addr[7:2]] <= m_wdata;
    end
    if (m_we) we_cnt <= we_cnt + 1;
    if (m_rv) resp_cnt <= resp_cnt + 1;
    if (m_addr == watch_addr) touch_cnt <= touch_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          sel;
    bit          wr;
    logic [1:0]  sz;
    bit          sg;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [1:0]  fault;
    int          lat;
    bit          chk_rd;
    int          we;
    bit          touch;
  } vec_t;

  function automatic vec_t mk(bit s, bit w, logic [1:0] z, bit g, logic [31:0] a,
                              logic [31:0] wd, logic [31:0] rd, logic [1:0] f, int l,
                              bit c, int we, bit t);
    vec_t v;
    v.sel = s; v.wr = w; v.sz = z; v.sg = g; v.addr = a; v.wdata = wd; v.rdata = rd;
    v.fault = f; v.lat = l; v.chk_rd = c; v.we = we; v.touch = t;
    return v;
  endfunction

  localparam int NVec = 18;
  vec_t vecs [NVec];

  task automatic run(input vec_t v, output logic [31:0] rd, output logic [1:0] flt,
                     output int lat, output int wes, output int touches);
    int we0, t0;
    @(negedge clk);
    sel = v.sel; req_write = v.wr; req_size = v.sz; req_signed = v.sg;
    req_addr = v.addr; req_wdata = v.wdata;
    watch_addr = {v.addr[31:2], 2'b00};
    we0 = we_cnt; t0 = touch_cnt;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = -1; rd = 'x; flt = 'x;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (m_rv) begin
        lat = c; rd = m_rd; flt = m_ft;
        break;
      end
    end
    @(negedge clk);
    wes = we_cnt - we0;
    touches = touch_cnt - t0;
  endtask

  initial begin
    logic [31:0] rd;
    logic [1:0]  flt;
    int lat, wes, touches, r0, w0;

    for (int i = 0; i < 64; i++) begin
      text_mem[i] = 32'h0;
      data_mem[i] = 32'h0;
    end
    text_mem[4] = 32'h1111_1111;
    data_mem[0] = 32'h0123_4567;
    data_mem[2] = 32'h5555_5555;

    //            sel wr sz    sg addr          wdata          rdata          flt  lat rd we t
    vecs[0]  = mk(0, 1, 2'b10, 0, 32'h1000_0004, 32'hDEAD_BEEF, 32'h0,         2'b00, 3, 0, 1, 1);
    vecs[1]  = mk(0, 0, 2'b01, 1, 32'h1000_0004, 32'h0,         32'hFFFF_DEAD, 2'b00, 2, 1, 0, 1);
    vecs[2]  = mk(0, 0, 2'b00, 0, 32'h1000_0007, 32'h0,         32'h0000_00EF, 2'b00, 2, 1, 0, 1);
    vecs[3]  = mk(0, 1, 2'b00, 0, 32'h1000_0006, 32'h7777_77A5, 32'h0,         2'b00, 3, 0, 1, 1);
    vecs[4]  = mk(0, 0, 2'b10, 0, 32'h1000_0004, 32'h0,         32'hDEAD_A5EF, 2'b00, 2, 1, 0, 1);
    vecs[5]  = mk(0, 0, 2'b10, 0, 32'h1000_0002, 32'h0,         32'h0,         2'b01, 1, 1, 0, 0);
    vecs[6]  = mk(1, 0, 2'b10, 0, 32'h1000_0002, 32'h0,         32'h0123_4567, 2'b00, 2, 1, 0, 1);
    vecs[7]  = mk(0, 0, 2'b00, 1, 32'h1000_0006, 32'h0,         32'hFFFF_FFA5, 2'b00, 2, 1, 0, 1);
    vecs[8]  = mk(0, 0, 2'b01, 0, 32'h1000_0006, 32'h0,         32'h0000_A5EF, 2'b00, 2, 1, 0, 1);
    vecs[9]  = mk(0, 0, 2'b10, 0, 32'h2000_0000, 32'h0,         32'h0,         2'b10, 2, 1, 0, 1);
    vecs[10] = mk(0, 1, 2'b10, 0, 32'h2000_0000, 32'h1234_5678, 32'h0,         2'b10, 2, 1, 0, 1);
    vecs[11] = mk(0, 1, 2'b10, 0, 32'h0000_0010, 32'hCAFE_F00D, 32'h0,         2'b11, 1, 0, 0, 0);
    vecs[12] = mk(0, 0, 2'b10, 0, 32'h0000_0010, 32'h0,         32'h1111_1111, 2'b00, 2, 1, 0, 1);
    vecs[13] = mk(1, 1, 2'b10, 0, 32'h0000_0010, 32'hCAFE_F00D, 32'h0,         2'b00, 3, 0, 1, 1);
    vecs[14] = mk(1, 0, 2'b10, 0, 32'h0000_0010, 32'h0,         32'hCAFE_F00D, 2'b00, 2, 1, 0, 1);
    vecs[15] = mk(0, 1, 2'b01, 0, 32'h1000_0000, 32'hFFFF_1234, 32'h0,         2'b00, 3, 0, 1, 1);
    vecs[16] = mk(0, 0, 2'b10, 0, 32'h1000_0000, 32'h0,         32'h1234_4567, 2'b00, 2, 1, 0, 1);
    vecs[17] = mk(0, 1, 2'b01, 0, 32'h1000_0001, 32'h0000_BBBB, 32'h1234_4567, 2'b01, 1, 1, 0, 0);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready",   {31'h0, rdy_a}, 32'h0);
    chk("rst_resp_v",  {31'h0, rv_a},  32'h0);
    chk("rst_rdata",   rd_a,           32'h0);
    chk("rst_fault",   {30'h0, ft_a},  32'h0);
    chk("rst_mem_we",  {31'h0, we_a},  32'h0);
    chk("rst_mem_addr", ma_a,          32'h0);
    chk("rst_mem_din", md_a,           32'h0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_ready", {31'h0, rdy_a}, 32'h1);

    for (int i = 0; i < NVec; i++) begin
      run(vecs[i], rd, flt, lat, wes, touches);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_fault", i), {30'h0, flt}, {30'h0, vecs[i].fault});
      if (vecs[i].chk_rd) chk($sformatf("v%0d_rdata", i), rd, vecs[i].rdata);
      chk($sformatf("v%0d_we_cycles", i), wes, vecs[i].we);
      chk($sformatf("v%0d_addr_touched", i), {31'h0, touches != 0}, {31'h0, vecs[i].touch});
    end
    chk("text_after_protect", text_mem[4], 32'hCAFE_F00D);

    // Reset during ACCESS of a byte store: no write, no response.
    @(negedge clk);
    sel = 1'b0; req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h1000_0008; req_wdata = 32'h0000_0099;
    r0 = resp_cnt; w0 = we_cnt;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rstacc_ready", {31'h0, rdy_a}, 32'h1);
    repeat (3) @(negedge clk);
    chk("rstacc_mem", data_mem[2], 32'h5555_5555);
    chk("rstacc_we", we_cnt - w0, 0);
    chk("rstacc_resp", resp_cnt - r0, 0);

    // Reset during WRITE: the write commits, no response follows.
    @(negedge clk);
    req_write = 1'b1; req_size = 2'b10; req_addr = 32'h1000_000C; req_wdata = 32'h0BAD_CAFE;
    r0 = resp_cnt;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rstwr_we_high", {31'h0, we_a}, 32'h1);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("rstwr_mem", data_mem[3], 32'h0BAD_CAFE);
    chk("rstwr_resp", resp_cnt - r0, 0);
    chk("rstwr_ready", {31'h0, rdy_a}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/arm_lsu.md
Name: arm_lsu

Overview:
Load/store unit between the CPU datapath and the data port of arm_memory. Accepts one load or store request at a time over a valid/ready handshake and converts it into word-wide memory accesses. Handles byte, halfword and word sizes with big-endian lane selection and optional sign extension. Sub-word stores use read-modify-write. Misaligned, unmapped and text-region write accesses are reported as faults.

Parameters:
ALIGN_CHECK, 1, 1: misaligned access faults; 0: low address bits below the access size are ignored.
TEXT_PROTECT, 1, 1: stores to addresses below TEXT_TOP fault.
TEXT_TOP, 32'h00000100, exclusive upper bound of the text region.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
req_valid  in  1  request present
req_ready  out  1  unit can accept a request
req_write  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as word)
req_signed  in  1  sign-extend sub-word loads
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned for sub-word
resp_valid  out  1  one-cycle response pulse
resp_rdata  out  32  load result
resp_fault  out  2  00 ok, 01 misaligned, 10 unmapped, 11 protected
mem_addr  out  32  word-aligned address to the memory port
mem_data_in  out  32  write data to the memory port
mem_we  out  1  write enable to the memory port
mem_excpt  in  1  memory exception bit for this port
mem_data_out  in  32  combinational read data from the memory port

Behaviour:
- Clock is clk. Reset is synchronous and active-high on reset; the single clock domain is clk.
- Reset values: state IDLE, req_ready=0 while reset is high, resp_valid=0, resp_rdata=0, resp_fault=00, mem_we=0, mem_addr=0, mem_data_in=0.
- States: IDLE, ACCESS, WRITE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch write/size/signed/addr/wdata.
  - Misaligned check when ALIGN_CHECK=1: half with addr[0]=1, or word with addr[1:0]!=0. If misaligned, set fault 01 and go to RESP.
  - If store and TEXT_PROTECT=1 and addr<TEXT_TOP, set fault 11 and go to RESP.
  - Otherwise go to ACCESS.
  - Faulted requests never drive mem_we.
- ACCESS:
  - mem_addr = {addr[31:2],2'b00}, mem_we=0.
  - If mem_excpt, set fault 10 and go to RESP.
  - Load: extract the lane from mem_data_out into resp_rdata, then go to RESP.
  - Store: register merged word, then go to WRITE.
- Lanes are big-endian:
  - Byte k=addr[1:0] occupies bits [31-8k -: 8].
  - Halfword with addr[1]=0 occupies [31:16]; with addr[1]=1 it occupies [15:0].
  - Word occupies [31:0].
  - Loads zero-extend, or sign-extend when req_signed=1.
- Merge: read word with only the target lane replaced by the low byte or half of wdata. A word store replaces all lanes.
- WRITE: mem_addr held, mem_data_in = merged word, mem_we=1 for exactly one cycle. The memory commits at the edge ending WRITE. Then go to RESP.
- RESP:
  - resp_valid=1 for one cycle, then go to IDLE.
  - resp_fault is valid with resp_valid and holds until the next response.
  - On a faulted load, resp_rdata=0. Stores leave resp_rdata unchanged.
- Latency from the accept edge to resp_valid: load 2 cycles, store 3 cycles, early fault 1 cycle.
- req_valid while not in IDLE is ignored; there is no buffering.
- Reset mid-operation: the next edge returns the unit to IDLE and drops mem_we/resp_valid. If reset is high during WRITE, that edge still commits the write, because mem_we was already asserted that cycle.

Test Plan:
1. Store word 0xDEADBEEF to 0x10000004. Then signed-half load from 0x10000004 returns 0xFFFFDEAD, fault 00. Unsigned byte load from 0x10000007 returns 0x000000EF.
2. Byte store 0x000000A5 to 0x10000006 (RMW). A following word load from 0x10000004 returns 0xDEADA5EF. mem_we is high for exactly one cycle.
3. Word load from 0x10000002 with ALIGN_CHECK=1 returns fault 01 one cycle after accept. mem_addr is never driven to that word. Repeat with ALIGN_CHECK=0: returns the word at 0x10000000.
4. Load from 0x20000000 returns fault 10 with rdata 0. A store to 0x20000000 gives fault 10 and mem_we never rises.
5. Word store to 0x00000010 with TEXT_PROTECT=1 returns fault 11 and text memory is unchanged. With TEXT_PROTECT=0 the store succeeds.
6. Reset asserted during ACCESS of a byte store leaves memory unchanged and the unit in IDLE. Reset asserted during WRITE commits the word, and there is no resp_valid.
